// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// tagging, 2-entry instruction FIFO and redirect flush with response dropping.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t           r_state;
    logic [31:0]      r_fetch_pc;
    logic [1:0][31:0] r_fifo_word;
    logic [1:0][31:0] r_fifo_pc;
    logic [1:0]       r_fcnt;
    logic [1:0][31:0] r_tag;
    logic [1:0]       r_out;
    logic [1:0]       r_drop;

    state_t           w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic [1:0][31:0] w_word_nxt;
    logic [1:0][31:0] w_fpc_nxt;
    logic [1:0]       w_fcnt_nxt;
    logic [1:0][31:0] w_tag_nxt;
    logic [1:0]       w_out_nxt;
    logic [1:0]       w_drop_nxt;
    logic             w_run;
    logic             w_credit;
    logic             w_hs;
    logic             w_rsp;
    logic             w_pop;
    logic             w_late;

    assign w_run    = (r_state == S_RUN);
    assign w_credit = ({1'b0, r_out} + {1'b0, r_fcnt}) < 3'd2;
    assign imem_req = w_run & ~redirect & w_credit;
    assign imem_addr = r_fetch_pc;
    assign w_hs     = imem_req & imem_gnt;
    assign w_rsp    = w_run & ~redirect & imem_rvalid & (r_out != 2'd0);
    assign instr_valid = (r_fcnt != 2'd0) & ~redirect;
    assign w_pop    = instr_valid & instr_ready;
    assign instr    = r_fifo_word[0];
    assign instr_pc = r_fifo_pc[0];
    // a response landing in the redirect cycle is consumed, not counted
    assign w_late   = imem_rvalid & (r_out != 2'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_fetch_pc;
        w_word_nxt  = r_fifo_word;
        w_fpc_nxt   = r_fifo_pc;
        w_fcnt_nxt  = r_fcnt;
        w_tag_nxt   = r_tag;
        w_out_nxt   = r_out;
        w_drop_nxt  = r_drop;

        if (w_pop) begin
            w_word_nxt[0] = r_fifo_word[1];
            w_fpc_nxt[0]  = r_fifo_pc[1];
            w_fcnt_nxt    = w_fcnt_nxt - 2'd1;
        end
        if (w_rsp) begin
            w_word_nxt[w_fcnt_nxt[0]] = imem_rdata;
            w_fpc_nxt[w_fcnt_nxt[0]]  = r_tag[0];
            w_fcnt_nxt = w_fcnt_nxt + 2'd1;
            w_tag_nxt[0] = r_tag[1];
            w_out_nxt    = w_out_nxt - 2'd1;
        end
        if (w_hs) begin
            w_tag_nxt[w_out_nxt[0]] = r_fetch_pc;
            w_out_nxt = w_out_nxt + 2'd1;
            w_pc_nxt  = r_fetch_pc + 32'd4;
        end

        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: w_state_nxt = S_RUN;
            S_FLUSH: begin
                if (imem_rvalid && r_drop != 2'd0) begin
                    w_drop_nxt = r_drop - 2'd1;
                    if (r_drop == 2'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase

        if (redirect) begin
            w_fcnt_nxt = 2'd0;
            w_out_nxt  = 2'd0;
            w_pc_nxt   = redirect_pc & 32'hFFFF_FFFC;
            if (r_state == S_RUN) begin
                w_drop_nxt = r_out - {1'b0, w_late};
            end else if (r_state != S_FLUSH) begin
                w_drop_nxt = 2'd0;
            end
            w_state_nxt = (w_drop_nxt != 2'd0) ? S_FLUSH : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_BOOT;
            r_fetch_pc  <= RESET_PC;
            r_fifo_word <= '0;
            r_fifo_pc   <= '0;
            r_fcnt      <= 2'd0;
            r_tag       <= '0;
            r_out       <= 2'd0;
            r_drop      <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_pc_nxt;
            r_fifo_word <= w_word_nxt;
            r_fifo_pc   <= w_fpc_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_tag       <= w_tag_nxt;
            r_out       <= w_out_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle directed table, then randomized traffic
// checked against an instruction-stream reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] W(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, gnt, rv;
        logic [31:0] rdata;
        logic        rdy, redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv, e_dat;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, gnt, rv, input logic [31:0] rdata,
                       input logic rdy, redir, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_iv, e_dat,
                       input logic [31:0] e_pc, e_instr);
        vec_t v;
        v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_dat = e_dat; v.e_pc = e_pc; v.e_instr = e_instr;
        tbl.push_back(v);
    endtask

    // memory and stream reference model
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rq_t;

    rq_t         mq[$];
    int          cyc;
    int          last_due;
    int          pops;
    logic [31:0] exp_req;
    logic [31:0] exp_pop;

    task automatic step(input bit allow_redir, input int p_rdy,
                        input int p_gnt);
        rq_t         e;
        logic [31:0] t;
        @(negedge clk);
        redirect    = allow_redir && ($urandom_range(0, 19) == 0);
        t = ($urandom_range(0, 3) == 0) ?
            (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        redirect_pc = t;
        instr_ready = ($urandom_range(0, 9) < p_rdy);
        imem_gnt    = ($urandom_range(0, 9) < p_gnt);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(0, 9) < 8) begin
            imem_rvalid = 1'b1;
            imem_rdata  = W(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        if (redirect) begin
            chk("redir_req", {31'd0, imem_req}, 32'd0);
            chk("redir_iv", {31'd0, instr_valid}, 32'd0);
            exp_req = t & 32'hFFFF_FFFC;
            exp_pop = t & 32'hFFFF_FFFC;
        end else begin
            if (imem_req && imem_gnt) begin
                chk("req_addr", imem_addr, exp_req);
                exp_req = exp_req + 32'd4;
                e.addr = imem_addr;
                e.due  = cyc + $urandom_range(1, 3);
                if (e.due < last_due) e.due = last_due;
                last_due = e.due;
                mq.push_back(e);
                chk("inflight_le2", (mq.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
            end
            if (instr_valid && instr_ready) begin
                chk("pop_pc", instr_pc, exp_pop);
                chk("pop_instr", instr, W(exp_pop));
                exp_pop = exp_pop + 32'd4;
                pops++;
            end
        end
        cyc++;
    endtask

    initial begin
        reset = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;

        //  rst gnt rv rdata rdy redir rpc | req addr iv dat pc instr
        add(0,1,1,32'hDEAD_BEEF,1,0,0,        0,32'h0,0,1,32'h0,32'h0);
        add(1,1,0,0,1,0,0,                    0,32'h0,0,0,0,0);
        add(1,1,0,0,1,0,0,                    1,32'h0,0,0,0,0);
        add(1,1,1,W(32'h0),1,0,0,             1,32'h4,0,0,0,0);
        add(1,1,1,W(32'h4),1,0,0,             0,32'h8,1,1,32'h0,W(32'h0));
        add(1,1,0,0,1,0,0,                    1,32'h8,1,1,32'h4,W(32'h4));
        add(1,1,1,W(32'h8),1,0,0,             1,32'hC,0,0,0,0);
        add(1,1,1,W(32'hC),0,0,0,             0,32'h10,1,1,32'h8,W(32'h8));
        add(1,1,0,0,0,0,0,                    0,32'h10,1,1,32'h8,W(32'h8));
        add(1,1,0,0,1,0,0,                    0,32'h10,1,1,32'h8,W(32'h8));
        add(1,1,0,0,0,0,0,                    1,32'h10,1,1,32'hC,W(32'hC));
        add(1,1,0,0,1,0,0,                    0,32'h14,1,1,32'hC,W(32'hC));
        add(1,1,0,0,1,0,0,                    1,32'h14,0,0,0,0);
        add(1,1,0,0,1,1,32'h103,              0,32'h18,0,0,0,0);
        add(1,1,1,W(32'h10),1,0,0,            0,32'h100,0,0,0,0);
        add(1,1,1,W(32'h14),1,0,0,            0,32'h100,0,0,0,0);
        add(1,1,0,0,1,0,0,                    1,32'h100,0,0,0,0);
        add(1,0,1,W(32'h100),1,0,0,           1,32'h104,0,0,0,0);
        add(1,1,0,0,0,0,0,                    1,32'h104,1,1,32'h100,W(32'h100));
        add(1,1,1,W(32'h104),1,1,32'h200,     0,32'h108,0,0,0,0);
        add(1,1,0,0,1,0,0,                    1,32'h200,0,0,0,0);
        add(1,0,1,W(32'h200),1,0,0,           1,32'h204,0,0,0,0);
        add(1,0,0,0,1,0,0,                    1,32'h204,1,1,32'h200,W(32'h200));
        add(1,1,0,0,1,1,32'hFFFF_FFFF,        0,32'h204,0,0,0,0);
        add(1,1,0,0,1,0,0,                    1,32'hFFFF_FFFC,0,0,0,0);
        add(1,1,1,W(32'hFFFF_FFFC),1,0,0,     1,32'h0,0,0,0,0);
        add(1,1,1,W(32'h0),1,0,0,             0,32'h4,1,1,32'hFFFF_FFFC,W(32'hFFFF_FFFC));
        add(1,1,0,0,1,0,0,                    1,32'h4,1,1,32'h0,W(32'h0));
        add(0,1,1,32'hDEAD_BEEF,1,0,0,        0,32'h0,0,1,32'h0,32'h0);
        add(1,1,1,32'hDEAD_BEEF,1,0,0,        0,32'h0,0,0,0,0);
        add(1,1,1,32'hDEAD_BEEF,1,0,0,        1,32'h0,0,0,0,0);
        add(1,0,1,W(32'h0),1,0,0,             1,32'h4,0,0,0,0);
        add(1,0,0,0,1,0,0,                    1,32'h4,1,1,32'h0,W(32'h0));

        repeat (2) @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset       = tbl[i].rst;
            imem_gnt    = tbl[i].gnt;
            imem_rvalid = tbl[i].rv;
            imem_rdata  = tbl[i].rdata;
            instr_ready = tbl[i].rdy;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            #1;
            chk($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d_iv", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_iv});
            if (tbl[i].e_dat) begin
                chk($sformatf("row%0d_pc", i), instr_pc, tbl[i].e_pc);
                chk($sformatf("row%0d_instr", i), instr, tbl[i].e_instr);
            end
        end

        @(negedge clk);
        reset = 1'b0;
        redirect = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        cyc = 0;
        last_due = 0;
        exp_req = 32'h0;
        exp_pop = 32'h0;
        for (int k = 0; k < 3000; k++) step(1'b1, 7, 7);

        pops = 0;
        for (int k = 0; k < 60; k++) step(1'b0, 10, 10);
        chk("liveness_pops", (pops >= 15) ? 32'd1 : 32'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
